// File: rtl/ctrl_cmd_pkg.sv
// Shared constants, bus payload layouts and FSM encoding for the control command engine.
package ctrl_cmd_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ERR_W  = 8;

  // Command/response field bit positions
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 28;
  localparam int unsigned TAG_MSB  = 27;
  localparam int unsigned TAG_LSB  = 24;
  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DATA_MSB = 15;
  localparam int unsigned DATA_LSB = 0;

  localparam int unsigned NUM_RW_REGS  = 6;
  localparam int unsigned ERR_REG_ADDR = 6;
  localparam int unsigned VER_REG_ADDR = 7;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  localparam logic [3:0] ST_OK  = 4'h8;
  localparam logic [3:0] ST_ERR = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [3:0]        tag;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } cmd_t;

  typedef struct packed {
    logic [3:0]        status;
    logic [3:0]        tag;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } resp_t;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [1:0] inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, a} + (ERR_W+1)'(inc);
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/ctrl_regfile.sv
// Control register storage: writable regs 0-5, error-count/version read-only views, live ctrl outputs.
module ctrl_regfile
  import ctrl_cmd_pkg::*;
#(
  parameter int unsigned     NREGS   = 8,
  parameter logic [REG_W-1:0] VERSION = 16'h0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  input  logic [ERR_W-1:0]  err_cnt,
  output logic [REG_W-1:0]  rdata_c,
  output logic              wr_ok_c,
  output logic              rd_ok_c,
  output logic [REG_W-1:0]  ctrl0,
  output logic [REG_W-1:0]  ctrl1
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [REG_W-1:0] regs [NREGS];
  logic [IDX_W-1:0] idx;
  logic             in_range;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = 32'(addr) < NREGS;
  assign rd_ok_c  = in_range;
  assign wr_ok_c  = in_range && (32'(addr) < NUM_RW_REGS);

  // Read mux: regs 6 and 7 are views, not storage
  always_comb begin
    rdata_c = '0;
    if (32'(addr) == ERR_REG_ADDR) begin
      rdata_c = {8'h00, err_cnt};
    end else if (32'(addr) == VER_REG_ADDR) begin
      rdata_c = VERSION;
    end else if (in_range) begin
      rdata_c = regs[idx];
    end
  end

  // ctrl outputs trail storage by one cycle so a write shows two cycles after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      ctrl0 <= '0;
      ctrl1 <= '0;
    end else begin
      if (we && wr_ok_c) regs[idx] <= wdata;
      ctrl0 <= regs[0];
      ctrl1 <= regs[1];
    end
  end

endmodule

// File: rtl/ctrl_cmd_engine.sv
// Command engine: accepts one command word, executes it against the register file, emits a response.
module ctrl_cmd_engine
  import ctrl_cmd_pkg::*;
#(
  parameter int unsigned      FT_DATA_WIDTH = 32,
  parameter int unsigned      NREGS         = 8,
  parameter logic [REG_W-1:0] VERSION       = 16'h0001
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FT_DATA_WIDTH-1:0] cmd_data_i,
  input  logic                     cmd_we_i,
  output logic                     cmd_ready_o,
  output logic [FT_DATA_WIDTH-1:0] resp_data_o,
  output logic                     resp_we_o,
  input  logic                     resp_full_i,
  output logic [REG_W-1:0]         ctrl0_o,
  output logic [REG_W-1:0]         ctrl1_o,
  output logic [ERR_W-1:0]         err_cnt_o
);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d, cmd_in;
  resp_t            resp_q, resp_d;
  logic             rdy_q, rdy_d;
  logic             resp_we_q, resp_we_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             drop_c, dec_err_c, reg_we_c;
  logic [REG_W-1:0] rdata_c;
  logic             wr_ok_c, rd_ok_c;

  assign cmd_in = cmd_data_i;

  ctrl_regfile #(
    .NREGS   (NREGS),
    .VERSION (VERSION)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_we_c),
    .addr    (cmd_q.addr),
    .wdata   (cmd_q.data),
    .err_cnt (err_q),
    .rdata_c (rdata_c),
    .wr_ok_c (wr_ok_c),
    .rd_ok_c (rd_ok_c),
    .ctrl0   (ctrl0_o),
    .ctrl1   (ctrl1_o)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    resp_d    = resp_q;
    rdy_d     = 1'b0;
    resp_we_d = 1'b0;
    reg_we_c  = 1'b0;
    dec_err_c = 1'b0;
    drop_c    = cmd_we_i && !rdy_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_we_i && rdy_q) begin
          cmd_d   = cmd_in;
          state_d = S_EXEC;
        end else begin
          rdy_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (cmd_q.opcode == OP_NOP) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end else if (cmd_q.opcode == OP_WRITE && wr_ok_c) begin
          reg_we_c = 1'b1;
          state_d  = S_IDLE;
          rdy_d    = 1'b1;
        end else begin
          state_d     = S_RESP;
          resp_we_d   = !resp_full_i;
          resp_d.tag  = cmd_q.tag;
          resp_d.addr = cmd_q.addr;
          if (cmd_q.opcode == OP_READ && rd_ok_c) begin
            resp_d.status = ST_OK;
            resp_d.data   = rdata_c;
          end else begin
            resp_d.status = ST_ERR;
            resp_d.data   = '0;
            dec_err_c     = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (resp_we_q) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end else begin
          resp_we_d = !resp_full_i;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d = sat_add(err_q, 2'(drop_c) + 2'(dec_err_c));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      resp_q    <= '0;
      rdy_q     <= 1'b0;
      resp_we_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      resp_q    <= resp_d;
      rdy_q     <= rdy_d;
      resp_we_q <= resp_we_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready_o = rdy_q;
  assign resp_we_o   = resp_we_q;
  assign resp_data_o = resp_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_ctrl_cmd_engine.sv
// Self-checking bench for ctrl_cmd_engine: directed scenarios plus randomized traffic against a behavioural model.
module tb_ctrl_cmd_engine;

  localparam logic [15:0] VER = 16'h0001;

  logic        clk;
  logic        reset;
  logic [31:0] cmd_data_i;
  logic        cmd_we_i;
  logic        cmd_ready_o;
  logic [31:0] resp_data_o;
  logic        resp_we_o;
  logic        resp_full_i;
  logic [15:0] ctrl0_o;
  logic [15:0] ctrl1_o;
  logic [7:0]  err_cnt_o;

  ctrl_cmd_engine #(
    .FT_DATA_WIDTH (32),
    .NREGS         (8),
    .VERSION       (VER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_data_i  (cmd_data_i),
    .cmd_we_i    (cmd_we_i),
    .cmd_ready_o (cmd_ready_o),
    .resp_data_o (resp_data_o),
    .resp_we_o   (resp_we_o),
    .resp_full_i (resp_full_i),
    .ctrl0_o     (ctrl0_o),
    .ctrl1_o     (ctrl1_o),
    .err_cnt_o   (err_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: expected outputs after each rising edge
  logic [15:0] m_regs [8];
  logic [15:0] m_ctrl0, m_ctrl1;
  int          m_err;
  logic        m_ready, m_we, m_rst;
  logic [31:0] m_data;
  logic        m_exec, m_hold;
  logic [31:0] m_cmd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] reg_view(input logic [7:0] a);
    logic [2:0] i;
    i = a[2:0];
    if (a < 8'd6) return m_regs[i];
    if (a == 8'd6) return {8'h00, 8'(m_err)};
    return VER;
  endfunction

  task automatic model_step(input logic we, input logic [31:0] w, input logic full, input logic rst);
    int         inc;
    logic [3:0] op;
    logic [7:0] a;
    logic [2:0] ai;
    m_rst = rst;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_ctrl0 = '0; m_ctrl1 = '0; m_err = 0;
      m_ready = 1'b0; m_we = 1'b0; m_data = '0;
      m_exec = 1'b0; m_hold = 1'b0; m_cmd = '0;
      return;
    end
    m_ctrl0 = m_regs[0];
    m_ctrl1 = m_regs[1];
    inc = (we && !m_ready) ? 1 : 0;
    if (m_hold) begin
      if (m_we) begin
        m_hold = 1'b0; m_we = 1'b0; m_ready = 1'b1;
      end else begin
        m_we = !full;
      end
    end else if (m_exec) begin
      m_exec = 1'b0;
      op = m_cmd[31:28];
      a  = m_cmd[23:16];
      ai = a[2:0];
      if (op == 4'h0 || (op == 4'h1 && a < 8'd6)) begin
        if (op == 4'h1) m_regs[ai] = m_cmd[15:0];
        m_ready = 1'b1;
      end else begin
        m_hold = 1'b1;
        m_we   = !full;
        if (op == 4'h2 && a < 8'd8) begin
          m_data = {4'h8, m_cmd[27:16], reg_view(a)};
        end else begin
          m_data = {4'hE, m_cmd[27:16], 16'h0000};
          inc++;
        end
      end
    end else if (we && m_ready) begin
      m_exec = 1'b1; m_cmd = w; m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
    m_err = (m_err + inc > 255) ? 255 : m_err + inc;
  endtask

  task automatic compare();
    chk("cmd_ready", 32'(cmd_ready_o), 32'(m_ready));
    chk("resp_we",   32'(resp_we_o),   32'(m_we));
    chk("ctrl0",     32'(ctrl0_o),     32'(m_ctrl0));
    chk("ctrl1",     32'(ctrl1_o),     32'(m_ctrl1));
    chk("err_cnt",   32'(err_cnt_o),   32'(m_err));
    if (m_we || m_rst) chk("resp_data", resp_data_o, m_data);
  endtask

  task automatic tick(input logic we, input logic [31:0] w, input logic full, input logic rst);
    reset = rst; cmd_we_i = we; cmd_data_i = w; resp_full_i = full;
    @(posedge clk);
    model_step(we, w, full, rst);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Wait (bounded) for a response pulse, check its word, then let the engine return to IDLE
  task automatic wait_pulse(input string name, input logic [31:0] exp);
    int k;
    k = 0;
    while (!resp_we_o && k < 20) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      k++;
    end
    chk({name, "_pulse"}, 32'(resp_we_o), 32'd1);
    chk(name, resp_data_o, exp);
    idle(1);
  endtask

  initial begin
    reset = 1'b1; cmd_we_i = 1'b0; cmd_data_i = '0; resp_full_i = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_resp_data", resp_data_o, 32'h0);
    idle(1);
    chk("ready_after_rst", 32'(cmd_ready_o), 32'd1);

    // Write reg 0
    tick(1'b1, 32'h1300_0005, 1'b0, 1'b0);
    idle(2);
    chk("write_ctrl0", 32'(ctrl0_o), 32'h0005);

    // Read version register
    tick(1'b1, 32'h2707_0000, 1'b0, 1'b0);
    wait_pulse("read_ver", 32'h8707_0001);

    // Out-of-range read and illegal opcode
    tick(1'b1, 32'h2A09_0000, 1'b0, 1'b0);
    wait_pulse("read_oor", 32'hEA09_0000);
    chk("err_after_oor", 32'(err_cnt_o), 32'd1);
    tick(1'b1, 32'h5000_0000, 1'b0, 1'b0);
    wait_pulse("illegal_op", 32'hE000_0000);
    chk("err_after_illegal", 32'(err_cnt_o), 32'd2);

    // Back-pressure: response held while FIFO full
    tick(1'b1, 32'h2000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      chk("full_no_we", 32'(resp_we_o), 32'd0);
      chk("full_not_ready", 32'(cmd_ready_o), 32'd0);
    end
    idle(1);
    chk("full_release_we", 32'(resp_we_o), 32'd1);
    chk("full_release_data", resp_data_o, 32'h8000_0005);
    idle(1);

    // Back-to-back valid words: odd words execute, even words drop
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    tick(1'b1, 32'h1002_AAAA, 1'b0, 1'b0);
    tick(1'b1, 32'h1003_CCCC, 1'b0, 1'b0);
    tick(1'b1, 32'h1004_BBBB, 1'b0, 1'b0);
    tick(1'b1, 32'h1005_DDDD, 1'b0, 1'b0);
    idle(1);
    chk("drop_err", 32'(err_cnt_o), 32'd2);
    tick(1'b1, 32'h2102_0000, 1'b0, 1'b0);
    wait_pulse("word1_kept", 32'h8102_AAAA);
    tick(1'b1, 32'h2103_0000, 1'b0, 1'b0);
    wait_pulse("word2_dropped", 32'h8103_0000);
    tick(1'b1, 32'h2104_0000, 1'b0, 1'b0);
    wait_pulse("word3_kept", 32'h8104_BBBB);
    tick(1'b1, 32'h2306_0000, 1'b0, 1'b0);
    wait_pulse("read_errcnt", 32'h8306_0002);
    tick(1'b1, 32'h1406_1111, 1'b0, 1'b0);
    wait_pulse("write_ro", 32'hE406_0000);

    // Reset during RESP discards the response
    tick(1'b1, 32'h1300_1234, 1'b0, 1'b0);
    tick(1'b1, 32'h1101_5678, 1'b0, 1'b0);
    idle(1);
    tick(1'b1, 32'h1101_5678, 1'b0, 1'b0);
    idle(2);
    chk("pre_rst_ctrl1", 32'(ctrl1_o), 32'h5678);
    tick(1'b1, 32'h2000_0000, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_in_resp_we", 32'(resp_we_o), 32'd0);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    chk("rst_in_resp_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_in_resp_ctrl0", 32'(ctrl0_o), 32'h0);
    chk("rst_in_resp_ctrl1", 32'(ctrl1_o), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic        we, full, rst;
      logic [3:0]  op;
      int          r;
      r = int'($urandom_range(0, 9));
      if (r < 1)      op = 4'h0;
      else if (r < 5) op = 4'h1;
      else if (r < 8) op = 4'h2;
      else            op = 4'($urandom_range(3, 15));
      we   = ($urandom_range(0, 9) < 6);
      full = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      tick(we, {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 10)), 16'($urandom)}, full, rst);
    end

    // Saturation: illegal words offered every cycle
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 300; i++) tick(1'b1, 32'hF0FF_0000, 1'b0, 1'b0);
    chk("err_saturated", 32'(err_cnt_o), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_cmd_engine.md
CTRL_CMD_ENGINE -- requirements
Module: ctrl_cmd_engine

Interface
REQ-001 Parameter FT_DATA_WIDTH, default 32: command/response word width; only 32 is supported.
REQ-002 Parameter NREGS, default 8: number of register addresses.
REQ-003 Parameter VERSION, default 16'h0001: value of read-only register 7.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_data_i  input  32  command word from the FTDI-to-CPU path.
REQ-007 cmd_we_i  input  1  command word valid, one word per cycle.
REQ-008 cmd_ready_o  output  1  engine accepts a word this cycle.
REQ-009 resp_data_o  output  32  response word to the CPU-to-FTDI command FIFO write port.
REQ-010 resp_we_o  output  1  response FIFO write enable.
REQ-011 resp_full_i  input  1  response FIFO full.
REQ-012 ctrl0_o, ctrl1_o  output  16 each  live contents of registers 0 and 1 (loopback, tx/rx mux, LEDs).
REQ-013 err_cnt_o  output  8  saturating error counter.

Function
REQ-014 Command format: [31:28] opcode, [27:24] tag, [23:16] addr, [15:0] data; opcodes 0x0 NOP, 0x1 WRITE, 0x2 READ; all others illegal.
REQ-015 Response format: [31:28] status (0x8 read OK, 0xE error), [27:24] tag echoed, [23:16] addr echoed, [15:0] read data or 16'h0000 on error.
REQ-016 FSM states: IDLE, EXEC, RESP; IDLE->EXEC on cmd_we_i; EXEC->RESP when a response is needed, else EXEC->IDLE; RESP->IDLE on the cycle resp_we_o is 1.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE; a word is captured when cmd_we_i && cmd_ready_o.
REQ-018 cmd_we_i while cmd_ready_o=0 SHALL drop the word and increment err_cnt_o; no response is generated.
REQ-019 WRITE to addr 0-5 SHALL update the register at the end of EXEC; new value is visible on ctrl*_o two cycles after the accept edge; no response.
REQ-020 READ to addr 0-7 SHALL produce status 0x8 with the register value; register 6 reads {8'h00, err_cnt_o}, register 7 reads VERSION.
REQ-021 WRITE to addr 6/7, any access with addr >= NREGS, or an illegal opcode SHALL produce status 0xE and increment err_cnt_o; no register changes.
REQ-022 NOP SHALL return to IDLE with no response and no side effects.
REQ-023 In RESP, resp_data_o SHALL be stable; resp_we_o = !resp_full_i for exactly one cycle; while full, the engine holds in RESP with resp_we_o=0.
REQ-024 Best-case throughput: WRITE/NOP one word per 2 cycles; READ one word per 3 cycles.
REQ-025 err_cnt_o SHALL saturate at 8'hFF; a simultaneous drop (REQ-018) and decode error in the same cycle increments it by 2, saturating.

Reset
REQ-026 While reset=1: state IDLE, all registers 0, err_cnt_o 0, resp_we_o 0, resp_data_o 0, cmd_ready_o 0.
REQ-027 cmd_ready_o SHALL be 1 on the first cycle after reset deasserts.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the pending command/response; no resp_we_o pulse.

Structure
REQ-029 Package ctrl_cmd_pkg holds opcode and status constants, field bit positions, and the FSM state encoding.
REQ-030 Sub-module ctrl_regfile holds the NREGS x 16 storage, write-protect decode, and read mux.

Verification
REQ-031 After reset, WRITE 0x1_3_00_0005 -> ctrl0_o = 16'h0005 two cycles after accept; resp_we_o stays 0.
REQ-032 READ 0x2_7_07_0000 -> one resp_we_o pulse, resp_data_o = 32'h8707_0001.
REQ-033 READ addr 0x09 tag 0xA -> resp_data_o = 32'hEA09_0000, err_cnt_o 0->1; illegal opcode 0x5 -> err_cnt_o 1->2.
REQ-034 resp_full_i=1 for 10 cycles during a READ -> resp_we_o 0 throughout, cmd_ready_o 0; one pulse the cycle after full drops.
REQ-035 cmd_we_i held high for 4 consecutive cycles with WRITE words -> words 1 and 3 executed, words 2 and 4 dropped, err_cnt_o = 2.
REQ-036 Reset pulsed during RESP -> no response written, registers 0, cmd_ready_o 1 on the first cycle after reset deasserts.
